// File: rtl/qoi_types.sv
// Shared type package: default address/data types for the buffering blocks,
// plus the bank-index type and bank-count default used by multi_buffer.
package qoi_types;

    localparam int DEPTH_DEFAULT = 256;
    localparam int W_DEFAULT     = 8;
    localparam int NBANK_DEFAULT = 2;

    typedef logic [$clog2(DEPTH_DEFAULT)-1:0] addr_t;
    typedef logic [W_DEFAULT-1:0]             byte_t;
    typedef logic [$clog2(NBANK_DEFAULT)-1:0] bank_idx_t;

endpackage

// File: rtl/multibuf_bank.sv
// One bank of the multi-buffer: single-clock RAM, one write port, one read
// port with a registered read. Only the read register is reset.
module multibuf_bank #(
    parameter int DEPTH = 256,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    // Storage write.
    // NOTE: the array has no reset branch so it maps onto block RAM; contents
    // after reset are whatever was last written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read-register value: load on a read strobe, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/multi_buffer.sv
// NBANK-way bank-rotating buffer between one writer and one reader.
// The writer fills its bank and commits it with wr_last; the reader consumes
// committed banks in order and hands them back with rd_release.
// Optional feature: define MULTI_BUFFER_LEN_EN to record a per-bank length
// (last write address + 1) at commit and expose it on rd_len.
module multi_buffer
    import qoi_types::*;
#(
    parameter int NBANK = NBANK_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = $bits(byte_t)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_cs,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [W-1:0]               wr_data,
    input  logic                       wr_last,
    output logic                       wr_avail,
    output logic                       wr_drop,
    input  logic                       rd_cs,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [W-1:0]               rd_data,
    input  logic                       rd_release,
    output logic                       rd_avail,
`ifdef MULTI_BUFFER_LEN_EN
    output logic [$clog2(DEPTH):0]     rd_len,
`endif
    output logic [$clog2(NBANK):0]     fill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NBANK);
    localparam int CW = BW + 1;

    logic [BW-1:0] wr_ptr_q, wr_ptr_d;
    logic [BW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_drop_q, wr_drop_d;
    logic [BW-1:0] rd_sel_q, rd_sel_d;

    logic wr_en;
    logic commit;
    logic rd_en;
    logic rel_en;

    logic [W-1:0] bank_rdata [NBANK];

    // Handshake qualification and next-state for pointers, count and drop flag.
    // Pointers wrap for free because NBANK is a power of two.
    always_comb begin
        wr_avail  = (count_q != CW'(NBANK));
        rd_avail  = (count_q != '0);
        wr_en     = wr_cs && wr_avail;
        commit    = wr_en && wr_last;
        rd_en     = rd_cs && rd_avail;
        rel_en    = rd_release && rd_avail;

        wr_ptr_d  = commit ? wr_ptr_q + BW'(1) : wr_ptr_q;
        rd_ptr_d  = rel_en ? rd_ptr_q + BW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({commit, rel_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wr_drop_d = wr_cs && !wr_avail;
        // Remember which bank the outstanding read targets so the output mux
        // stays on it even if rd_ptr moves on in the same cycle.
        rd_sel_d  = rd_en ? rd_ptr_q : rd_sel_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_drop_q <= 1'b0;
            rd_sel_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_drop_q <= wr_drop_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic bank_we;
        logic bank_re;

        assign bank_we = wr_en && (wr_ptr_q == BW'(i));
        assign bank_re = rd_en && (rd_ptr_q == BW'(i));

        multibuf_bank #(
            .DEPTH (DEPTH),
            .W     (W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (bank_re),
            .raddr (rd_addr),
            .rdata (bank_rdata[i])
        );
    end

    // Each bank holds its last read word, so selecting the last-read bank
    // gives the required hold behaviour without an extra register stage.
    assign rd_data    = bank_rdata[rd_sel_q];
    assign wr_drop    = wr_drop_q;
    assign fill_count = count_q;

`ifdef MULTI_BUFFER_LEN_EN
    localparam int LW = AW + 1;

    logic [LW-1:0] len_q [NBANK];
    logic [LW-1:0] len_d [NBANK];

    // Capture the committed length into the writer's bank slot.
    always_comb begin
        len_d = len_q;
        if (commit) begin
            len_d[wr_ptr_q] = LW'(wr_addr) + LW'(1);
        end
    end

    // Length registers; small enough to clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBANK; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            len_q <= len_d;
        end
    end

    assign rd_len = len_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_multi_buffer.sv
// Self-checking bench for multi_buffer. Instance a: NBANK=2, instance b: NBANK=4.
module tb_multi_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs, index 0 drives instance a, index 1 drives instance b.
    logic [1:0]      rst, wr_cs, wr_last, rd_cs, rd_release;
    logic [1:0][7:0] wr_addr, wr_data, rd_addr;

    logic       wa_a, wa_b, wd_a, wd_b, ra_a, ra_b;
    logic [7:0] rdd_a, rdd_b;
    logic [1:0] fc_a;
    logic [2:0] fc_b;

    logic [1:0]      wr_avail, wr_drop, rd_avail;
    logic [1:0][7:0] rd_data;
    logic [1:0][2:0] fill_count;

    assign wr_avail   = {wa_b, wa_a};
    assign wr_drop    = {wd_b, wd_a};
    assign rd_avail   = {ra_b, ra_a};
    assign rd_data    = {rdd_b, rdd_a};
    assign fill_count = {fc_b, {1'b0, fc_a}};

`ifdef MULTI_BUFFER_LEN_EN
    logic [8:0] rl_a, rl_b;
`endif

    multi_buffer #(.NBANK(2), .DEPTH(256), .W(8)) u_dut_a (
`ifdef MULTI_BUFFER_LEN_EN
        .rd_len     (rl_a),
`endif
        .clk        (clk),
        .rst        (rst[0]),
        .wr_cs      (wr_cs[0]),
        .wr_addr    (wr_addr[0]),
        .wr_data    (wr_data[0]),
        .wr_last    (wr_last[0]),
        .wr_avail   (wa_a),
        .wr_drop    (wd_a),
        .rd_cs      (rd_cs[0]),
        .rd_addr    (rd_addr[0]),
        .rd_data    (rdd_a),
        .rd_release (rd_release[0]),
        .rd_avail   (ra_a),
        .fill_count (fc_a)
    );

    multi_buffer #(.NBANK(4), .DEPTH(256), .W(8)) u_dut_b (
`ifdef MULTI_BUFFER_LEN_EN
        .rd_len     (rl_b),
`endif
        .clk        (clk),
        .rst        (rst[1]),
        .wr_cs      (wr_cs[1]),
        .wr_addr    (wr_addr[1]),
        .wr_data    (wr_data[1]),
        .wr_last    (wr_last[1]),
        .wr_avail   (wa_b),
        .wr_drop    (wd_b),
        .rd_cs      (rd_cs[1]),
        .rd_addr    (rd_addr[1]),
        .rd_data    (rdd_b),
        .rd_release (rd_release[1]),
        .rd_avail   (ra_b),
        .fill_count (fc_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       d;
        logic [7:0] exp;
    } sb_t;

    sb_t   sb_q[$];
    string sb_name_q[$];

    typedef struct packed {
        logic       rel;
        logic [7:0] addr;
        logic [7:0] exp_data;
        logic [2:0] exp_fill;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int d, input int addr, input int data, input bit last);
        wr_cs[d]   = 1'b1;
        wr_addr[d] = 8'(addr);
        wr_data[d] = 8'(data);
        wr_last[d] = last;
        cyc();
        wr_cs[d]   = 1'b0;
        wr_last[d] = 1'b0;
    endtask

    // Word a of the bank holds (a + seed) mod 256.
    task automatic write_bank(input int d, input int seed, input int last_addr, input bit commit);
        for (int a = 0; a <= last_addr; a++) begin
            write_word(d, a, a + seed, commit && (a == last_addr));
        end
    endtask

    task automatic release_bank(input int d);
        rd_release[d] = 1'b1;
        cyc();
        rd_release[d] = 1'b0;
    endtask

    task automatic compare_read();
        sb_t   e;
        string n;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb_q.pop_front();
            n = sb_name_q.pop_front();
            check(n, rd_data[e.d], e.exp);
        end
    endtask

    task automatic issue_read(input int d, input int addr, input int exp, input string name);
        rd_cs[d]   = 1'b1;
        rd_addr[d] = 8'(addr);
        sb_q.push_back('{d: 1'(d), exp: 8'(exp)});
        sb_name_q.push_back(name);
        cyc();
        rd_cs[d] = 1'b0;
        compare_read();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 2'b11;
        wr_cs      = '0;
        wr_last    = '0;
        rd_cs      = '0;
        rd_release = '0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_addr    = '0;

        vecs[0] = '{rel: 1'b0, addr: 8'd3,  exp_data: 8'd3,  exp_fill: 3'd4};
        vecs[1] = '{rel: 1'b0, addr: 8'd15, exp_data: 8'd15, exp_fill: 3'd4};
        vecs[2] = '{rel: 1'b1, addr: 8'd0,  exp_data: 8'd16, exp_fill: 3'd3};
        vecs[3] = '{rel: 1'b0, addr: 8'd7,  exp_data: 8'd23, exp_fill: 3'd3};
        vecs[4] = '{rel: 1'b1, addr: 8'd3,  exp_data: 8'd35, exp_fill: 3'd2};
        vecs[5] = '{rel: 1'b1, addr: 8'd15, exp_data: 8'd63, exp_fill: 3'd1};

        cyc();
        cyc();
        rst = 2'b00;

        // Reset state on both instances.
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_wr_avail_%0d", d), wr_avail[d], 1);
            check($sformatf("rst_rd_avail_%0d", d), rd_avail[d], 0);
            check($sformatf("rst_fill_%0d", d),     fill_count[d], 0);
            check($sformatf("rst_wr_drop_%0d", d),  wr_drop[d], 0);
            check($sformatf("rst_rd_data_%0d", d),  rd_data[d], 0);
        end
`ifdef MULTI_BUFFER_LEN_EN
        check("rst_rd_len_a", rl_a, 0);
        check("rst_rd_len_b", rl_b, 0);
`endif

        // ---------------- instance a (NBANK=2) ----------------
        write_bank(0, 0, 255, 1'b1);
        check("a_fill_after_commit", fill_count[0], 1);
        check("a_rd_avail_after_commit", rd_avail[0], 1);
        check("a_wr_avail_after_commit", wr_avail[0], 1);
        issue_read(0, 0,   0,   "a_read0");
        issue_read(0, 255, 255, "a_read255");
        issue_read(0, 10,  10,  "a_read10");

        release_bank(0);
        check("a_fill_after_release", fill_count[0], 0);
        check("a_rd_avail_after_release", rd_avail[0], 0);

        // Release and read with nothing filled: both ignored.
        release_bank(0);
        check("a_fill_idle_release", fill_count[0], 0);
        check("a_wr_avail_idle_release", wr_avail[0], 1);
        rd_cs[0]   = 1'b1;
        rd_addr[0] = 8'd20;
        cyc();
        rd_cs[0] = 1'b0;
        cyc();
        check("a_rd_data_hold_idle", rd_data[0], 10);

        // Next bank lands in bank1 and the reader must be there too.
        write_bank(0, 100, 255, 1'b1);
        check("a_fill_bank1", fill_count[0], 1);
        issue_read(0, 5, 105, "a_read_bank1");

        // Fill bank0 up to the last word, then commit + release + read together.
        write_bank(0, 50, 254, 1'b0);
        wr_cs[0]      = 1'b1;
        wr_addr[0]    = 8'd255;
        wr_data[0]    = 8'd49;
        wr_last[0]    = 1'b1;
        rd_release[0] = 1'b1;
        rd_cs[0]      = 1'b1;
        rd_addr[0]    = 8'd7;
        sb_q.push_back('{d: 1'b0, exp: 8'd107});
        sb_name_q.push_back("a_read_releasing_bank");
        cyc();
        wr_cs[0]      = 1'b0;
        wr_last[0]    = 1'b0;
        rd_release[0] = 1'b0;
        rd_cs[0]      = 1'b0;
        compare_read();
        check("a_fill_commit_and_release", fill_count[0], 1);
        issue_read(0, 3,   53, "a_rd_ptr_advanced");
        issue_read(0, 255, 49, "a_last_word_of_commit");

        // Writer must now be on bank1.
        write_bank(0, 200, 255, 1'b1);
        check("a_fill_full", fill_count[0], 2);
        check("a_wr_avail_full", wr_avail[0], 0);
        release_bank(0);
        check("a_fill_after_release2", fill_count[0], 1);
        issue_read(0, 9, 209, "a_wr_ptr_advanced");
        release_bank(0);
        check("a_fill_empty_again", fill_count[0], 0);

`ifdef MULTI_BUFFER_LEN_EN
        write_bank(0, 0, 99, 1'b1);
        check("a_rd_len_100", rl_a, 100);
        check("a_fill_len_bank", fill_count[0], 1);
`endif

        // ---------------- instance b (NBANK=4) ----------------
        for (int k = 0; k < 4; k++) begin
            write_bank(1, 16 * k, 15, 1'b1);
        end
        check("b_fill_full", fill_count[1], 4);
        check("b_wr_avail_full", wr_avail[1], 0);
        check("b_rd_avail_full", rd_avail[1], 1);
        check("b_wr_drop_quiet", wr_drop[1], 0);

        write_word(1, 3, 8'hEE, 1'b1);
        check("b_wr_drop_pulse", wr_drop[1], 1);
        cyc();
        check("b_wr_drop_clears", wr_drop[1], 0);
        check("b_fill_after_drop", fill_count[1], 4);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rel) begin
                release_bank(1);
            end
            check($sformatf("b_vec%0d_fill", i), fill_count[1], 32'(vecs[i].exp_fill));
            issue_read(1, int'(vecs[i].addr), int'(vecs[i].exp_data), $sformatf("b_vec%0d_data", i));
        end

        // Build count=3 plus a half-written bank, then reset.
        write_bank(1, 8'h80, 15, 1'b1);
        write_bank(1, 8'h90, 15, 1'b1);
        check("b_fill_three", fill_count[1], 3);
        write_bank(1, 8'hA0, 7, 1'b0);
        rst[1] = 1'b1;
        cyc();
        check("b_rst_fill", fill_count[1], 0);
        check("b_rst_wr_avail", wr_avail[1], 1);
        check("b_rst_rd_avail", rd_avail[1], 0);
        check("b_rst_rd_data", rd_data[1], 0);
        check("b_rst_wr_drop", wr_drop[1], 0);
        rst[1] = 1'b0;

        write_bank(1, 8'h40, 15, 1'b1);
        check("b_fill_after_rst", fill_count[1], 1);
        issue_read(1, 2, 8'h42, "b_read_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
